enc_bundler_accum: RTL and testbench
====================================

# enc_bundler_accum

Bundling stage directly downstream of the per-feature binder pack in the sparse HDC encoder. Each accepted cycle, it takes one pack of FEATURES_PER_CC shifted hypervectors and adds them bitwise into per-bit counters. After NUM_PACKS packs, it thresholds the counters into one sparse sample hypervector. The result is held with a valid/ready handshake until the class-memory / similarity stage consumes it.

## Interface
- HV_DIM, 1024: hypervector width in bits.
- FEATURES_PER_CC, 8: shifted HVs delivered per cycle (one binder pack).
- NUM_PACKS, 4: packs per sample; must be ≥ 1.
- THRESHOLD, 2: minimum per-bit count for an output bit to be set; must be ≥ 1.
- CNT_W, $clog2(FEATURES_PER_CC*NUM_PACKS+1): per-bit counter width.

Ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  reset; asynchronous, active-low.
- start_encoding  in  1  single-cycle pulse; clears counters and opens a new sample.
- in_valid  in  1  shifted_hv holds a valid pack this cycle.
- shifted_hv  in  HV_DIM x [0:FEATURES_PER_CC-1]  binder outputs.
- in_ready  out  1  block accepts a pack this cycle.
- out_valid  out  1  out_hv holds a completed sample HV.
- out_ready  in  1  downstream accepts out_hv.
- out_hv  out  HV_DIM  bundled, thresholded sample HV.
- busy  out  1  high in ACCUM and DONE.

## Operation
- State machine: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0; packs are ignored.
  - start_encoding moves the block to ACCUM. On the same edge, all counters are cleared and pack_cnt is set to 0.
- ACCUM:
  - in_ready=1.
  - A pack is accepted when in_valid=1.
  - On accept, for each bit b: cnt[b] += popcount over i of shifted_hv[i][b]. pack_cnt increments.
  - On accepting the pack with pack_cnt==NUM_PACKS-1:
    - out_hv[b] is registered as (cnt[b] + this pack's contribution ≥ THRESHOLD).
    - The block moves to DONE.
- DONE:
  - out_valid=1; out_hv and the counters are frozen; in_ready=0.
  - When out_valid && out_ready, the block goes to IDLE and out_valid drops on the next edge.
- start_encoding in ACCUM restarts the sample: counters cleared, pack_cnt=0, state stays ACCUM. If in_valid is high in the same cycle, that pack is discarded.
- start_encoding in DONE is ignored. The held result must be consumed first.
- Per-bit addition is computed at CNT_W+1 bits, then reduced per the Configuration section.
- pack_cnt width is $clog2(NUM_PACKS)+1. It never wraps, because the block leaves ACCUM at the final pack.

## Timing
- Reset values:
  - state=IDLE, pack_cnt=0, cnt[*]=0.
  - out_hv=0, out_valid=0, in_ready=0, busy=0.
- Asynchronous reset mid-sample discards all partial state immediately. No out_valid is produced for the aborted sample.
- Latency: out_valid rises on the clock edge that accepts the last pack, i.e. it is visible in the cycle after that pack.
- Throughput:
  - NUM_PACKS accept cycles, plus ≥1 DONE cycle, plus 1 IDLE cycle, plus the start pulse.
  - Back-to-back samples need start_encoding in the IDLE cycle after the handshake.
- Handshake:
  - out_hv and out_valid stay stable while out_valid && !out_ready.
  - out_ready may be high before out_valid; it has no effect outside DONE.
- in_valid gaps in ACCUM stall accumulation; no data is lost.
- out_hv keeps its last value after DONE until the next sample's final pack.

## Configuration
- ENC_BUNDLER_SAT_EN defined:
  - Each counter saturates at 2^CNT_W-1.
  - Any CNT_W ≥ $clog2(THRESHOLD+1) then gives correct thresholding.
- ENC_BUNDLER_SAT_EN undefined:
  - Counters wrap modulo 2^CNT_W; there is no saturation logic.
  - Correct only when CNT_W meets the default formula.

## Test plan
Bench parameters: HV_DIM=8, FEATURES_PER_CC=2, NUM_PACKS=2, THRESHOLD=2, CNT_W default (3) unless noted.
- Reset: assert nrst=0 in any state → out_valid=0, in_ready=0, busy=0, out_hv=8'h00, state IDLE.
- Basic bundle:
  - Stimulus: start pulse; pack0 = {8'h0F, 8'h03}; pack1 = {8'h01, 8'h80}.
  - Expected: per-bit counts b0=3, b1=2, b2=1, b3=1, b7=1 → out_hv=8'h03, with out_valid asserted one cycle after pack1.
- Backpressure and stall:
  - Stimulus: in_valid low for 3 cycles between packs; out_ready low for 5 cycles in DONE.
  - Expected: result is still 8'h03; out_hv and out_valid stay stable throughout; in_ready=0 in DONE; start_encoding in DONE is ignored.
- Restart:
  - Stimulus: start, pack {8'hFF, 8'hFF}, then start_encoding together with in_valid, then packs {8'h10, 8'h10} and {8'h00, 8'h00}.
  - Expected: out_hv=8'h10 (the first pack and the collision pack are both discarded).
- Saturation, with CNT_W=2 and THRESHOLD=3:
  - Stimulus: all four HVs = 8'h01.
  - With ENC_BUNDLER_SAT_EN: out_hv=8'h01.
  - Without it: count wraps to 0 → out_hv=8'h00.
- Reset mid-operation:
  - Stimulus: nrst low after pack0; then a full sample with all HVs 8'h00.
  - Expected: no out_valid for the aborted sample; the next sample gives out_hv=8'h00.

Source files
------------

// File: rtl/enc_bundler_accum.sv
// Bundling stage: accumulates NUM_PACKS packs of shifted HVs into per-bit counters, then thresholds them.
// Define ENC_BUNDLER_SAT_EN to make the per-bit counters saturate instead of wrap.
module enc_bundler_accum #(
   parameter int HV_DIM          = 1024,
   parameter int FEATURES_PER_CC = 8,
   parameter int NUM_PACKS       = 4,
   parameter int THRESHOLD       = 2,
   parameter int CNT_W           = $clog2(FEATURES_PER_CC*NUM_PACKS+1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start_encoding,
   input  logic              in_valid,
   input  logic [HV_DIM-1:0] shifted_hv [FEATURES_PER_CC],
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HV_DIM-1:0] out_hv,
   output logic              busy
);

   localparam int PW  = $clog2(FEATURES_PER_CC+1);
   localparam int PCW = $clog2(NUM_PACKS)+1;
   localparam logic [31:0] THR = THRESHOLD;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [PCW-1:0]    pack_cnt_q, pack_cnt_d;
   logic [HV_DIM-1:0] out_hv_q, out_hv_d;
   logic [HV_DIM-1:0] thr_vec;
   logic              cnt_clear;
   logic              cnt_load;

   genvar gi;
   generate
      for (gi = 0; gi < HV_DIM; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic [PW-1:0]    pop;
         logic [CNT_W-1:0] red;
`ifdef ENC_BUNDLER_SAT_EN
         localparam logic [CNT_W-1:0] CNT_MAX = '1;
         logic [CNT_W:0]   sum;
`endif

         always_comb begin
            pop = '0;
            for (int i = 0; i < FEATURES_PER_CC; i++) begin
               pop = pop + PW'(shifted_hv[i][gi]);
            end
`ifdef ENC_BUNDLER_SAT_EN
            sum = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(pop);
            red = (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
`else
            // Plain modular add: wraps at 2^CNT_W, no saturation logic.
            red = cnt_q + CNT_W'(pop);
`endif
         end

         always_comb begin
            cnt_d = cnt_q;
            if (cnt_clear) begin
               cnt_d = '0;
            end else if (cnt_load) begin
               cnt_d = red;
            end
         end

         assign thr_vec[gi] = ({{(32-CNT_W){1'b0}}, red} >= THR);

         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      pack_cnt_d = pack_cnt_q;
      out_hv_d   = out_hv_q;
      cnt_clear  = 1'b0;
      cnt_load   = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_encoding) begin
               state_d    = S_ACCUM;
               pack_cnt_d = '0;
               cnt_clear  = 1'b1;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            // A restart wins over a pack arriving in the same cycle.
            if (start_encoding) begin
               pack_cnt_d = '0;
               cnt_clear  = 1'b1;
            end else if (in_valid) begin
               cnt_load   = 1'b1;
               pack_cnt_d = pack_cnt_q + 1'b1;
               if (pack_cnt_q == PCW'(NUM_PACKS-1)) begin
                  out_hv_d = thr_vec;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         pack_cnt_q <= '0;
         out_hv_q   <= '0;
      end else begin
         state_q    <= state_d;
         pack_cnt_q <= pack_cnt_d;
         out_hv_q   <= out_hv_d;
      end
   end

   assign out_hv = out_hv_q;

endmodule

// File: tb/tb_enc_bundler_accum.sv
// Bench for enc_bundler_accum: directed cases plus random traffic against an integer-count model.
// Two DUTs share the stimulus; the second uses CNT_W=2/THRESHOLD=3 to exercise wrap/saturation.
module tb_enc_bundler_accum;

   localparam int HV = 8;
   localparam int FPC = 2;
   localparam int NP = 2;
`ifdef ENC_BUNDLER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         start_encoding = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [HV-1:0] shv [FPC];
   logic         in_ready_a, out_valid_a, busy_a;
   logic         in_ready_b, out_valid_b, busy_b;
   logic [HV-1:0] out_hv_a, out_hv_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   enc_bundler_accum #(.HV_DIM(HV), .FEATURES_PER_CC(FPC), .NUM_PACKS(NP),
                       .THRESHOLD(2), .CNT_W(3)) u_a (
      .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .in_valid(in_valid),
      .shifted_hv(shv), .in_ready(in_ready_a), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_hv(out_hv_a), .busy(busy_a));

   enc_bundler_accum #(.HV_DIM(HV), .FEATURES_PER_CC(FPC), .NUM_PACKS(NP),
                       .THRESHOLD(3), .CNT_W(2)) u_b (
      .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .in_valid(in_valid),
      .shifted_hv(shv), .in_ready(in_ready_b), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_hv(out_hv_b), .busy(busy_b));

   // Behavioural model: unbounded integer counts per bit; width effects applied only at threshold time.
   int           m_mode = 0;   // 0 idle, 1 accumulating, 2 holding result
   int           m_packs = 0;
   int           m_cnt [HV];
   logic [HV-1:0] m_out_a = '0;
   logic [HV-1:0] m_out_b = '0;

   function automatic int popbit(input int b);
      int s = 0;
      for (int i = 0; i < FPC; i++) s += int'(shv[i][b]);
      return s;
   endfunction

   function automatic logic [HV-1:0] final_hv(input int w, input int thr);
      logic [HV-1:0] r = '0;
      for (int b = 0; b < HV; b++) begin
         int total = m_cnt[b] + popbit(b);
         int maxv = (1 << w) - 1;
         int v = SAT ? ((total > maxv) ? maxv : total) : (total % (1 << w));
         r[b] = (v >= thr);
      end
      return r;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_mode  <= 0;
         m_packs <= 0;
         m_out_a <= '0;
         m_out_b <= '0;
         for (int b = 0; b < HV; b++) m_cnt[b] <= 0;
      end else begin
         if (m_mode == 0) begin
            if (start_encoding) begin
               m_mode  <= 1;
               m_packs <= 0;
               for (int b = 0; b < HV; b++) m_cnt[b] <= 0;
            end
         end else if (m_mode == 1) begin
            if (start_encoding) begin
               m_packs <= 0;
               for (int b = 0; b < HV; b++) m_cnt[b] <= 0;
            end else if (in_valid) begin
               for (int b = 0; b < HV; b++) m_cnt[b] <= m_cnt[b] + popbit(b);
               m_packs <= m_packs + 1;
               if (m_packs + 1 == NP) begin
                  m_out_a <= final_hv(3, 2);
                  m_out_b <= final_hv(2, 3);
                  m_mode  <= 2;
               end
            end
         end else begin
            if (out_ready) m_mode <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_valid_a", 32'(out_valid_a), 32'(m_mode == 2));
         chk("m_out_valid_b", 32'(out_valid_b), 32'(m_mode == 2));
         chk("m_in_ready_a", 32'(in_ready_a), 32'(m_mode == 1));
         chk("m_in_ready_b", 32'(in_ready_b), 32'(m_mode == 1));
         chk("m_busy_a", 32'(busy_a), 32'(m_mode != 0));
         chk("m_busy_b", 32'(busy_b), 32'(m_mode != 0));
         chk("m_out_hv_a", 32'(out_hv_a), 32'(m_out_a));
         chk("m_out_hv_b", 32'(out_hv_b), 32'(m_out_b));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start_encoding = 1'b1;
      step();
      start_encoding = 1'b0;
   endtask

   task automatic pack(input logic [HV-1:0] a, input logic [HV-1:0] b);
      shv[0] = a;
      shv[1] = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic consume(input string name);
      int n = 0;
      while (!out_valid_a && n < 20) begin
         step();
         n++;
      end
      chk({name, "_valid_seen"}, 32'(out_valid_a), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({name, "_idle_after"}, 32'(busy_a), 32'd0);
   endtask

   initial begin
      shv[0] = '0;
      shv[1] = '0;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_in_ready", 32'(in_ready_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_out_hv", 32'(out_hv_a), 32'h00);
      nrst = 1'b1;
      chk_en = 1'b1;
      step();

      // Basic bundle
      pulse_start();
      pack(8'h0F, 8'h03);
      pack(8'h01, 8'h80);
      chk("basic_latency", 32'(out_valid_a), 32'd1);
      chk("basic_hv", 32'(out_hv_a), 32'h03);
      consume("basic");

      // Stall between packs, then backpressure with an ignored start in DONE
      pulse_start();
      pack(8'h0F, 8'h03);
      repeat (3) step();
      pack(8'h01, 8'h80);
      for (int c = 0; c < 5; c++) begin
         start_encoding = (c == 2);
         step();
         chk("bp_hv", 32'(out_hv_a), 32'h03);
         chk("bp_valid", 32'(out_valid_a), 32'd1);
         chk("bp_in_ready", 32'(in_ready_a), 32'd0);
      end
      start_encoding = 1'b0;
      consume("bp");

      // Restart: first pack and the colliding pack are discarded
      pulse_start();
      pack(8'hFF, 8'hFF);
      start_encoding = 1'b1;
      pack(8'hFF, 8'hFF);
      start_encoding = 1'b0;
      pack(8'h10, 8'h10);
      pack(8'h00, 8'h00);
      chk("restart_hv", 32'(out_hv_a), 32'h10);
      consume("restart");

      // Saturation vs wrap on the CNT_W=2 / THRESHOLD=3 instance
      pulse_start();
      pack(8'h01, 8'h01);
      pack(8'h01, 8'h01);
      chk("sat_hv_b", 32'(out_hv_b), SAT ? 32'h01 : 32'h00);
      chk("sat_hv_a", 32'(out_hv_a), 32'h01);
      consume("sat");

      // Asynchronous reset mid-sample
      pulse_start();
      pack(8'h0F, 8'h0F);
      nrst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy_a), 32'd0);
      chk("arst_hv", 32'(out_hv_a), 32'h00);
      step();
      nrst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("arst_no_valid", 32'(out_valid_a), 32'd0);
      end
      pulse_start();
      pack(8'h00, 8'h00);
      pack(8'h00, 8'h00);
      chk("arst_next_hv", 32'(out_hv_a), 32'h00);
      consume("arst_next");

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         shv[0] = HV'($urandom);
         shv[1] = HV'($urandom);
         start_encoding = ($urandom_range(0, 7) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 2) == 0);
         nrst      = ($urandom_range(0, 199) != 0);
         step();
      end
      nrst = 1'b1;
      start_encoding = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
